decode_burst_sequencer: RTL and testbench
=========================================

Name: decode_burst_sequencer

Overview:
- Upstream stage that generates the decode index bus and enable for the fanout decode/capture stage.
- Accepts burst requests (start index, length) through a valid/ready handshake and buffers them in a small FIFO.
- Each cycle it issues one registered index/enable beat. Indices increment with wrap at FANOUT-1, so the downstream decode sees exactly one selected output bit per enabled cycle.
- Supports hold (stall), back-to-back bursts with no bubble, and burst-done signalling.

Parameters:
- FANOUT, 64, number of decode targets; legal indices are 0..FANOUT-1 (FANOUT need not be a power of two).
- IO_SIZE, $clog2(FANOUT), index bus width.
- DEPTH, 4, request FIFO depth; power of two, minimum 2.
- CNT_W, 16, width of the issued-beat counter.

Ports:
- clk  input  1  rising-edge clock.
- resetN  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- reqValid  input  1  request present.
- reqReady  output  1  FIFO can accept; equals !full and is combinational from the FIFO level only.
- reqStart  input  IO_SIZE  first index of the burst; values >= FANOUT are reduced by taking reqStart mod FANOUT at enqueue.
- reqLen  input  IO_SIZE  burst length minus 1 (0 means 1 beat); effective length is min(reqLen+1, FANOUT).
- hold  input  1  stall; while high, no beat issues and no pop occurs.
- inpBus  output  IO_SIZE  registered index for the current beat.
- enable  output  1  registered beat-valid.
- burstDone  output  1  registered one-cycle pulse, high in the same cycle as a burst's last beat.
- busy  output  1  high when state is RUN or the FIFO is non-empty.
- fifoLevel  output  $clog2(DEPTH)+1  current FIFO occupancy.
- issueCount  output  CNT_W  total enabled beats since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset (resetN=0 at a clock edge):
  - enable=0, inpBus=0, burstDone=0, issueCount=0.
  - FIFO emptied (fifoLevel=0), state=IDLE, internal curIdx=0, beatsLeft=0.
  - Reset mid-burst discards the in-flight burst and all queued requests.
- Enqueue: a push occurs when reqValid && reqReady at the edge. When the FIFO is full, reqReady=0 even if a pop occurs in the same cycle; no simultaneous push-on-full.
- Simultaneous push and pop on a non-full, non-empty FIFO: level unchanged; order is preserved.
- States: IDLE and RUN. Internal curIdx is the next index to issue; beatsLeft is the number of beats remaining after the last issued beat.
- Every edge with hold=1: enable<=0, burstDone<=0, state/curIdx/beatsLeft unchanged, no pop. Pushes are still accepted.
- IDLE, hold=0:
  - FIFO empty: enable<=0, burstDone<=0.
  - FIFO non-empty: pop (start S, length L). Then enable<=1, inpBus<=S, curIdx<=S+1 (wrap FANOUT-1 to 0), beatsLeft<=L.
  - If L==0, burstDone<=1 and stay IDLE; otherwise go to RUN.
- RUN, hold=0:
  - beatsLeft>0: enable<=1, inpBus<=curIdx, curIdx advances with wrap, beatsLeft decrements.
  - burstDone<=1 when the decremented value is 0; state becomes IDLE in that same edge.
- Back-to-back: the first beat of the next queued burst issues on the edge immediately after the last beat of the previous one (IDLE pops at once). No bubble.
- Latency: a request pushed into an empty FIFO while IDLE and hold=0 at edge t gives enable=1 with inpBus=start after edge t+1.
- issueCount increments on every edge where enable is loaded with 1.
- Wrap: an index sequence crossing FANOUT-1 continues at 0. A length clipped to FANOUT visits every index exactly once.
- enable=0 never occurs within a burst unless hold was high on the previous edge.

Test Plan (FANOUT=64, DEPTH=4):
- Reset: hold resetN=0 for 2 cycles with reqValid=1 -> enable=0, inpBus=0, fifoLevel=0, reqReady=1, issueCount=0 after release.
- Single burst: push start=5, len=2 at edge t -> enable=1 on cycles t+1..t+3 with inpBus 5,6,7; burstDone=1 only with 7; enable=0 at t+4; issueCount=3.
- Wrap and back-to-back: push (62,3) then (10,0) -> inpBus 62,63,0,1,10 on consecutive cycles; burstDone high with 1 and with 10.
- Hold: during burst (20,4), assert hold for 2 cycles after index 21 -> sequence 20,21,(gap,gap),22,23,24; no index skipped or repeated.
- Full FIFO: hold=1, push 4 requests -> fifoLevel=4, reqReady=0; a 5th reqValid is not accepted. Release hold -> bursts emerge in push order; reqReady returns to 1 after the first pop.
- Mid-burst reset: assert resetN=0 during beat 3 of (0,63) with 2 queued requests -> the next cycle shows enable=0 and fifoLevel=0; after release, nothing issues until a new push.

Source files
------------

// File: rtl/decode_burst_sequencer.sv
// Burst sequencer feeding the fanout decode stage: queues (start, length) requests
// and issues one registered index/enable beat per cycle with wrap at FANOUT-1.
module decode_burst_sequencer #(
  parameter int FANOUT  = 64,
  parameter int IO_SIZE = $clog2(FANOUT),
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     reqValid,
  output logic                     reqReady,
  input  logic [IO_SIZE-1:0]       reqStart,
  input  logic [IO_SIZE-1:0]       reqLen,
  input  logic                     hold,
  output logic [IO_SIZE-1:0]       inpBus,
  output logic                     enable,
  output logic                     burstDone,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifoLevel,
  output logic [CNT_W-1:0]         issueCount
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [IO_SIZE-1:0] LAST_IDX = IO_SIZE'(FANOUT - 1);
  localparam logic [IO_SIZE:0]   FANOUT_X = (IO_SIZE + 1)'(FANOUT);
  localparam logic [LVL_W-1:0]   DEPTH_L  = LVL_W'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // state is kept as a named enum so checkers can bind to it directly
  state_t state;

  logic [IO_SIZE-1:0] fifo_start [DEPTH];
  logic [IO_SIZE-1:0] fifo_len   [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   level;

  logic [IO_SIZE-1:0] cur_idx;
  logic [IO_SIZE-1:0] beats_left;

  logic [IO_SIZE:0]   start_x;
  logic [IO_SIZE-1:0] start_norm;
  logic [IO_SIZE-1:0] len_norm;
  logic [IO_SIZE-1:0] head_start;
  logic [IO_SIZE-1:0] head_len;
  logic               push;
  logic               pop;

  function automatic logic [IO_SIZE-1:0] inc_idx(input logic [IO_SIZE-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IO_SIZE'(1);
  endfunction

  // Requests are normalised at enqueue so the issue path only ever sees legal values.
  always_comb begin
    start_x    = {1'b0, reqStart};
    start_norm = reqStart;
    if (start_x >= FANOUT_X) begin
      start_norm = IO_SIZE'(start_x - FANOUT_X);
    end
    len_norm = (reqLen > LAST_IDX) ? LAST_IDX : reqLen;
  end

  // Handshake: a request is taken on any edge where reqValid and reqReady are both
  // high; reqReady depends only on the FIFO level, so a same-cycle pop never frees a full slot.
  assign reqReady   = (level != DEPTH_L);
  assign push       = reqValid && reqReady;
  assign pop        = !hold && (state == IDLE) && (level != '0);
  assign head_start = fifo_start[rd_ptr];
  assign head_len   = fifo_len[rd_ptr];
  assign busy       = (state == RUN) || (level != '0);
  assign fifoLevel  = level;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_start[wr_ptr] <= start_norm;
      fifo_len[wr_ptr]   <= len_norm;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // beats_left counts beats still owed after the one just issued.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state      <= IDLE;
      cur_idx    <= '0;
      beats_left <= '0;
      enable     <= 1'b0;
      inpBus     <= '0;
      burstDone  <= 1'b0;
      issueCount <= '0;
    end else if (hold) begin
      enable    <= 1'b0;
      burstDone <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            enable     <= 1'b1;
            inpBus     <= head_start;
            cur_idx    <= inc_idx(head_start);
            beats_left <= head_len;
            burstDone  <= (head_len == '0);
            state      <= (head_len == '0) ? IDLE : RUN;
            issueCount <= issueCount + CNT_W'(1);
          end else begin
            enable    <= 1'b0;
            burstDone <= 1'b0;
          end
        end
        RUN: begin
          if (beats_left != '0) begin
            enable     <= 1'b1;
            inpBus     <= cur_idx;
            cur_idx    <= inc_idx(cur_idx);
            beats_left <= beats_left - IO_SIZE'(1);
            burstDone  <= (beats_left == IO_SIZE'(1));
            issueCount <= issueCount + CNT_W'(1);
            if (beats_left == IO_SIZE'(1)) begin
              state <= IDLE;
            end
          end else begin
            enable    <= 1'b0;
            burstDone <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          enable    <= 1'b0;
          burstDone <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decode_burst_sequencer.sv
// Bench for decode_burst_sequencer: directed scenarios plus randomized traffic
// checked against a queue-based beat model.
module tb_decode_burst_sequencer;

  localparam int FANOUT = 64;
  localparam int IO     = 6;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req_valid;
  logic             req_ready;
  logic [IO-1:0]    req_start;
  logic [IO-1:0]    req_len;
  logic             hold;
  logic [IO-1:0]    inp_bus;
  logic             enable;
  logic             burst_done;
  logic             busy;
  logic [2:0]       fifo_level;
  logic [CNT_W-1:0] issue_count;

  int n_checks = 0;
  int n_errors = 0;

  // model: queued requests as (start, beat count); beats of current burst as {last, idx}
  int               mq_start[$];
  int               mq_beats[$];
  logic [IO:0]      exp_q[$];
  logic             m_en;
  logic             m_done;
  logic [IO-1:0]    m_idx;
  logic [CNT_W-1:0] m_cnt;

  decode_burst_sequencer #(
    .FANOUT(FANOUT), .IO_SIZE(IO), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .resetN(reset_n), .reqValid(req_valid), .reqReady(req_ready),
    .reqStart(req_start), .reqLen(req_len), .hold(hold), .inpBus(inp_bus),
    .enable(enable), .burstDone(burst_done), .busy(busy),
    .fifoLevel(fifo_level), .issueCount(issue_count)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    bit accept;
    int s;
    int n;
    logic [IO:0] b;
    if (!reset_n) begin
      mq_start.delete();
      mq_beats.delete();
      exp_q.delete();
      m_en = 1'b0; m_done = 1'b0; m_idx = '0; m_cnt = '0;
      return;
    end
    accept = req_valid && (mq_start.size() < DEPTH);
    if (hold) begin
      m_en = 1'b0; m_done = 1'b0;
    end else begin
      if (exp_q.size() == 0 && mq_start.size() > 0) begin
        s = mq_start.pop_front();
        n = mq_beats.pop_front();
        for (int k = 0; k < n; k++) exp_q.push_back({(k == n - 1), IO'((s + k) % FANOUT)});
      end
      if (exp_q.size() > 0) begin
        b = exp_q.pop_front();
        m_en = 1'b1; m_idx = b[IO-1:0]; m_done = b[IO]; m_cnt = m_cnt + 1'b1;
      end else begin
        m_en = 1'b0; m_done = 1'b0;
      end
    end
    if (accept) begin
      mq_start.push_back(int'(req_start) % FANOUT);
      mq_beats.push_back((int'(req_len) + 1 > FANOUT) ? FANOUT : int'(req_len) + 1);
    end
  endtask

  task automatic step(input bit rv, input int st, input int ln, input bit h, input bit rn);
    req_valid = rv; req_start = IO'(st); req_len = IO'(ln); hold = h; reset_n = rn;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    step(1, 5, 2, 0, 0);
    step(1, 5, 2, 0, 0);
    req_valid = 1'b0;
    #1;
    n_checks++; if (enable !== 1'b0) begin n_errors++; $display("FAIL reset_enable: got %0b want 0", enable); end
    n_checks++; if (inp_bus !== '0) begin n_errors++; $display("FAIL reset_inp_bus: got %0d want 0", inp_bus); end
    n_checks++; if (fifo_level !== 3'd0) begin n_errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %0b want 1", req_ready); end
    n_checks++; if (issue_count !== '0) begin n_errors++; $display("FAIL reset_count: got %0d want 0", issue_count); end
    n_checks++; if (burst_done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %0b want 0", burst_done); end
  endtask

  task automatic test_single_burst();
    step(1, 5, 2, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1);
      n_checks++; if (enable !== 1'b1) begin n_errors++; $display("FAIL single_en[%0d]: got %0b want 1", i, enable); end
      n_checks++; if (inp_bus !== IO'(5 + i)) begin n_errors++; $display("FAIL single_idx[%0d]: got %0d want %0d", i, inp_bus, 5 + i); end
      n_checks++; if (burst_done !== (i == 2)) begin n_errors++; $display("FAIL single_done[%0d]: got %0b want %0b", i, burst_done, (i == 2)); end
    end
    step(0, 0, 0, 0, 1);
    n_checks++; if (enable !== 1'b0) begin n_errors++; $display("FAIL single_end_en: got %0b want 0", enable); end
    n_checks++; if (issue_count !== 16'd3) begin n_errors++; $display("FAIL single_count: got %0d want 3", issue_count); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL single_busy: got %0b want 0", busy); end
  endtask

  task automatic test_wrap_back_to_back();
    int  seq[5] = '{62, 63, 0, 1, 10};
    bit  dn[5]  = '{0, 0, 0, 1, 1};
    step(1, 62, 3, 0, 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) step(1, 10, 0, 0, 1);
      else        step(0, 0, 0, 0, 1);
      n_checks++; if (enable !== 1'b1) begin n_errors++; $display("FAIL wrap_en[%0d]: got %0b want 1", i, enable); end
      n_checks++; if (inp_bus !== IO'(seq[i])) begin n_errors++; $display("FAIL wrap_idx[%0d]: got %0d want %0d", i, inp_bus, seq[i]); end
      n_checks++; if (burst_done !== dn[i]) begin n_errors++; $display("FAIL wrap_done[%0d]: got %0b want %0b", i, burst_done, dn[i]); end
    end
    step(0, 0, 0, 0, 1);
    n_checks++; if (enable !== 1'b0) begin n_errors++; $display("FAIL wrap_end_en: got %0b want 0", enable); end
    n_checks++; if (issue_count !== 16'd8) begin n_errors++; $display("FAIL wrap_count: got %0d want 8", issue_count); end
  endtask

  task automatic test_hold();
    bit h[7]   = '{0, 0, 1, 1, 0, 0, 0};
    bit en[7]  = '{1, 1, 0, 0, 1, 1, 1};
    int idx[7] = '{20, 21, 0, 0, 22, 23, 24};
    step(1, 20, 4, 0, 1);
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 0, h[i], 1);
      n_checks++; if (enable !== en[i]) begin n_errors++; $display("FAIL hold_en[%0d]: got %0b want %0b", i, enable, en[i]); end
      if (en[i]) begin
        n_checks++; if (inp_bus !== IO'(idx[i])) begin n_errors++; $display("FAIL hold_idx[%0d]: got %0d want %0d", i, inp_bus, idx[i]); end
      end
      n_checks++; if (burst_done !== (i == 6)) begin n_errors++; $display("FAIL hold_done[%0d]: got %0b want %0b", i, burst_done, (i == 6)); end
    end
    step(0, 0, 0, 0, 1);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL hold_busy: got %0b want 0", busy); end
  endtask

  task automatic test_full_fifo();
    int st[4]  = '{1, 2, 3, 4};
    int ln[4]  = '{0, 1, 0, 0};
    int idx[5] = '{1, 2, 3, 3, 4};
    bit dn[5]  = '{1, 0, 1, 1, 1};
    for (int i = 0; i < 4; i++) step(1, st[i], ln[i], 1, 1);
    n_checks++; if (fifo_level !== 3'd4) begin n_errors++; $display("FAIL full_level: got %0d want 4", fifo_level); end
    n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL full_ready: got %0b want 0", req_ready); end
    step(1, 50, 0, 1, 1);
    n_checks++; if (fifo_level !== 3'd4) begin n_errors++; $display("FAIL full_reject: got %0d want 4", fifo_level); end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 1);
      n_checks++; if (enable !== 1'b1) begin n_errors++; $display("FAIL full_en[%0d]: got %0b want 1", i, enable); end
      n_checks++; if (inp_bus !== IO'(idx[i])) begin n_errors++; $display("FAIL full_idx[%0d]: got %0d want %0d", i, inp_bus, idx[i]); end
      n_checks++; if (burst_done !== dn[i]) begin n_errors++; $display("FAIL full_done[%0d]: got %0b want %0b", i, burst_done, dn[i]); end
      if (i == 0) begin
        n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL full_ready_back: got %0b want 1", req_ready); end
        n_checks++; if (fifo_level !== 3'd3) begin n_errors++; $display("FAIL full_level_pop: got %0d want 3", fifo_level); end
      end
    end
    step(0, 0, 0, 0, 1);
    n_checks++; if (enable !== 1'b0) begin n_errors++; $display("FAIL full_end_en: got %0b want 0", enable); end
    n_checks++; if (fifo_level !== 3'd0) begin n_errors++; $display("FAIL full_end_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_mid_reset();
    step(1, 0, 63, 0, 1);
    step(1, 5, 0, 0, 1);
    step(1, 6, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    n_checks++; if (inp_bus !== 6'd2) begin n_errors++; $display("FAIL mid_beat3: got %0d want 2", inp_bus); end
    n_checks++; if (fifo_level !== 3'd2) begin n_errors++; $display("FAIL mid_queued: got %0d want 2", fifo_level); end
    step(0, 0, 0, 0, 0);
    n_checks++; if (enable !== 1'b0) begin n_errors++; $display("FAIL mid_en: got %0b want 0", enable); end
    n_checks++; if (fifo_level !== 3'd0) begin n_errors++; $display("FAIL mid_level: got %0d want 0", fifo_level); end
    n_checks++; if (issue_count !== '0) begin n_errors++; $display("FAIL mid_count: got %0d want 0", issue_count); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1);
      n_checks++; if (enable !== 1'b0) begin n_errors++; $display("FAIL mid_after_en[%0d]: got %0b want 0", i, enable); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL mid_after_busy[%0d]: got %0b want 0", i, busy); end
    end
  endtask

  task automatic test_random();
    int ln;
    for (int c = 0; c < 600; c++) begin
      ln = ($urandom_range(0, 9) == 0) ? 63 : $urandom_range(0, 6);
      step($urandom_range(0, 1), $urandom_range(0, 63), ln,
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 149) != 0));
      n_checks++; if (enable !== m_en) begin n_errors++; $display("FAIL rand_en[%0d]: got %0b want %0b", c, enable, m_en); end
      if (m_en) begin
        n_checks++; if (inp_bus !== m_idx) begin n_errors++; $display("FAIL rand_idx[%0d]: got %0d want %0d", c, inp_bus, m_idx); end
      end
      n_checks++; if (burst_done !== m_done) begin n_errors++; $display("FAIL rand_done[%0d]: got %0b want %0b", c, burst_done, m_done); end
      n_checks++; if (fifo_level !== 3'(mq_start.size())) begin n_errors++; $display("FAIL rand_level[%0d]: got %0d want %0d", c, fifo_level, mq_start.size()); end
      n_checks++; if (req_ready !== (mq_start.size() < DEPTH)) begin n_errors++; $display("FAIL rand_ready[%0d]: got %0b want %0b", c, req_ready, (mq_start.size() < DEPTH)); end
      n_checks++; if (busy !== (exp_q.size() > 0 || mq_start.size() > 0)) begin n_errors++; $display("FAIL rand_busy[%0d]: got %0b want %0b", c, busy, (exp_q.size() > 0 || mq_start.size() > 0)); end
      n_checks++; if (issue_count !== m_cnt) begin n_errors++; $display("FAIL rand_count[%0d]: got %0d want %0d", c, issue_count, m_cnt); end
    end
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_start = '0; req_len = '0; hold = 1'b0;
    m_en = 1'b0; m_done = 1'b0; m_idx = '0; m_cnt = '0;
    test_reset();
    test_single_burst();
    test_wrap_back_to_back();
    test_hold();
    test_full_fifo();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
